// File: rtl/dmem_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_write_scheduler
//  Description : Shares the single write port of the data memory between two
//                requesters (A, B) with round-robin arbitration and a
//                valid/ready handshake. On command, it runs a clear sweep that
//                writes zero to every location, one location per cycle.
//
//  Ports       : clk, reset            clock, synchronous active-high reset
//                a_valid/a_addr/a_data requester A write request
//                a_ready               A's write commits at this clock edge
//                b_valid/b_addr/b_data requester B write request
//                b_ready               B's write commits at this clock edge
//                clear_start           request a full-memory clear sweep
//                busy                  clear sweep in progress
//                clear_done            one-cycle pulse after the last clear write
//                mem_we/mem_waddr/mem_wdata  memory write port
//
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_write_scheduler #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    // Last sweep address: the sweep leaves CLEAR on this count.
    localparam logic [ADDR_W-1:0] c_LAST_CNT = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_last_grant_b;   // 1: B was granted last, so A wins the next tie
    logic [ADDR_W-1:0]   r_sweep_cnt;
    logic                r_clear_done;

    logic                w_in_arb;
    logic                w_in_clear;
    logic                w_grant_a;
    logic                w_grant_b;

    // Reset gates every write-side output so nothing reaches the memory
    // while reset is asserted, whatever state the registers are in.
    always_comb begin
        w_in_arb   = (r_state == ST_ARB)   && !reset;
        w_in_clear = (r_state == ST_CLEAR) && !reset;

        // On a tie the requester opposite to the last grant wins.
        w_grant_a  = w_in_arb && a_valid && (!b_valid ||  r_last_grant_b);
        w_grant_b  = w_in_arb && b_valid && (!a_valid || !r_last_grant_b);

        a_ready    = w_grant_a;
        b_ready    = w_grant_b;

        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        if (w_in_clear) begin
            mem_we    = 1'b1;
            mem_waddr = r_sweep_cnt;
        end else if (w_grant_a) begin
            mem_we    = 1'b1;
            mem_waddr = a_addr;
            mem_wdata = a_data;
        end else if (w_grant_b) begin
            mem_we    = 1'b1;
            mem_waddr = b_addr;
            mem_wdata = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_ARB;
            r_last_grant_b <= 1'b1;
            r_sweep_cnt    <= '0;
            r_clear_done   <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (w_grant_a) begin
                        r_last_grant_b <= 1'b0;
                    end else if (w_grant_b) begin
                        r_last_grant_b <= 1'b1;
                    end
                    // The grant in this cycle still completes; the sweep
                    // starts on the next one.
                    if (clear_start) begin
                        r_state     <= ST_CLEAR;
                        r_sweep_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    // Counter wraps to zero naturally on the final write.
                    r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    if (r_sweep_cnt == c_LAST_CNT) begin
                        r_state      <= ST_ARB;
                        r_clear_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign busy       = (r_state == ST_CLEAR);
    assign clear_done = r_clear_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_write_scheduler
//  Description : Directed self-checking bench for dmem_write_scheduler with a
//                behavioural 16x8 memory attached to the write port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_write_scheduler;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              reset;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              clear_start;
    logic              busy;
    logic              clear_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] tb_mem [DEPTH];

    int checks;
    int failures;

    dmem_write_scheduler #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model attached to the write port.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: cross the rising edge, land just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'h00;

        // ---------------- 1: reset with all inputs active ----------------
        reset = 1'b1; a_valid = 1'b1; a_addr = 4'd9; a_data = 8'h99;
        b_valid = 1'b1; b_addr = 4'd6; b_data = 8'h66; clear_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_mem_we",     32'(mem_we),     32'd0);
            check("rst_a_ready",    32'(a_ready),    32'd0);
            check("rst_b_ready",    32'(b_ready),    32'd0);
            check("rst_busy",       32'(busy),       32'd0);
            check("rst_clear_done", 32'(clear_done), 32'd0);
        end

        // ---------------- 2: only A ----------------
        reset = 1'b0; clear_start = 1'b0; b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'hA5;
        #1;
        check("onlyA_a_ready",   32'(a_ready),   32'd1);
        check("onlyA_b_ready",   32'(b_ready),   32'd0);
        check("onlyA_mem_we",    32'(mem_we),    32'd1);
        check("onlyA_mem_waddr", 32'(mem_waddr), 32'd3);
        check("onlyA_mem_wdata", 32'(mem_wdata), 32'hA5);
        tick();
        a_valid = 1'b0;
        #1;
        check("idle_mem_we",    32'(mem_we),    32'd0);
        check("idle_mem_waddr", 32'(mem_waddr), 32'd0);
        check("idle_mem_wdata", 32'(mem_wdata), 32'd0);
        check("idle_a_ready",   32'(a_ready),   32'd0);
        check("mem3_after_A",   32'(tb_mem[3]), 32'hA5);

        // Fresh reset so last_grant=B and A wins the first tie.
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ---------------- 3: round robin ----------------
        a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_a_ready",   32'(a_ready),   (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_b_ready",   32'(b_ready),   (i % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_mem_waddr", 32'(mem_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_mem_wdata", 32'(mem_wdata), (i % 2 == 0) ? 32'h11 : 32'h22);
            tick();
        end
        a_valid = 1'b0;
        #1;
        check("onlyB_b_ready", 32'(b_ready), 32'd1);
        check("onlyB_a_ready", 32'(a_ready), 32'd0);
        tick();
        a_valid = 1'b1;
        #1;
        check("tie_after_B_a_ready", 32'(a_ready), 32'd1);
        check("tie_after_B_b_ready", 32'(b_ready), 32'd0);
        tick();

        // ---------------- 4: clear with B pending ----------------
        a_valid = 1'b0; b_valid = 1'b1; b_addr = 4'd5; b_data = 8'h55; clear_start = 1'b1;
        #1;
        check("clr_start_b_ready", 32'(b_ready),   32'd1);
        check("clr_start_waddr",   32'(mem_waddr), 32'd5);
        check("clr_start_busy",    32'(busy),      32'd0);
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("sweep_busy",    32'(busy),      32'd1);
            check("sweep_mem_we",  32'(mem_we),    32'd1);
            check("sweep_waddr",   32'(mem_waddr), 32'(i));
            check("sweep_wdata",   32'(mem_wdata), 32'd0);
            check("sweep_b_ready", 32'(b_ready),   32'd0);
            check("sweep_done",    32'(clear_done), 32'd0);
            tick();
        end
        #1;
        check("done_pulse",   32'(clear_done), 32'd1);
        check("done_busy",    32'(busy),       32'd0);
        check("done_b_ready", 32'(b_ready),    32'd1);
        check("done_waddr",   32'(mem_waddr),  32'd5);
        tick();
        b_valid = 1'b0;
        #1;
        check("done_one_cycle", 32'(clear_done), 32'd0);
        check("mem3_cleared",   32'(tb_mem[3]),  32'd0);
        check("mem5_kept_B",    32'(tb_mem[5]),  32'h55);

        // ---------------- 5: back-to-back sweeps ----------------
        // last_grant=B here, so ties go A (cycle 0), B (17), A (34).
        a_valid = 1'b1; a_addr = 4'd10; a_data = 8'hAA;
        b_valid = 1'b1; b_addr = 4'd11; b_data = 8'hBB;
        clear_start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            check("b2b_done",    32'(clear_done), (k == 17 || k == 34) ? 32'd1 : 32'd0);
            check("b2b_busy",    32'(busy),
                  (k == 0 || k == 17 || k == 34) ? 32'd0 : 32'd1);
            check("b2b_a_ready", 32'(a_ready),    (k == 0 || k == 34) ? 32'd1 : 32'd0);
            check("b2b_b_ready", 32'(b_ready),    (k == 17) ? 32'd1 : 32'd0);
            tick();
        end
        clear_start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("b2b_abort_busy", 32'(busy),       32'd0);
        check("b2b_abort_done", 32'(clear_done), 32'd0);

        // ---------------- 6: reset mid-sweep ----------------
        for (int i = 0; i < DEPTH; i++) begin
            a_valid = 1'b1; a_addr = 4'(i); a_data = 8'(8'h80 + i);
            tick();
        end
        a_valid = 1'b0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("abort_sweep_waddr", 32'(mem_waddr), 32'(i));
            tick();
        end
        reset = 1'b1;
        #1;
        check("abort_rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("abort_busy",   32'(busy),       32'd0);
        check("abort_done",   32'(clear_done), 32'd0);
        check("abort_mem_we", 32'(mem_we),     32'd0);
        tick();
        check("abort_no_done_later", 32'(clear_done), 32'd0);
        for (int i = 0; i < 7; i++) begin
            check("abort_mem_cleared", 32'(tb_mem[i]), 32'd0);
        end
        for (int i = 8; i < DEPTH; i++) begin
            check("abort_mem_kept", 32'(tb_mem[i]), 32'(8'h80 + i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
